// File: rtl/usart_tx_fifo_if.sv
// usart_tx_fifo_if: byte-queue handshake between a producer/transmitter side and the TX FIFO
interface usart_tx_fifo_if #(parameter int DEPTH_LOG2 = 4);
   logic [7:0]          write_data;
   logic                write_strobe;
   logic                flush;
   logic                clear_overflow;
   logic [7:0]          tx_data;
   logic                tx_valid;
   logic                tx_ready;
   logic [DEPTH_LOG2:0] count;
   logic                empty;
   logic                full;
   logic                overflow;
   modport master (
      output write_data, write_strobe, flush, clear_overflow, tx_ready,
      input  tx_data, tx_valid, count, empty, full, overflow
   );
   modport slave (
      input  write_data, write_strobe, flush, clear_overflow, tx_ready,
      output tx_data, tx_valid, count, empty, full, overflow
   );
endinterface

// File: rtl/usart_tx_fifo.sv
// usart_tx_fifo: byte FIFO feeding a USART transmitter, with sticky overflow and flush
module usart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input logic            comm_clock,
   input logic            reset,
   usart_tx_fifo_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2:0]   cnt;
   logic                  ovf;
   logic                  pop;
   logic                  push;
   logic                  drop;
   // handshake decode; a pop frees a slot so a push into a full queue is still taken
   always_comb begin
      pop  = bus.tx_ready && cnt != '0;
      push = bus.write_strobe && (cnt != DEPTH_CNT || pop);
      drop = bus.write_strobe && cnt == DEPTH_CNT && !pop;
   end
   // storage array, deliberately not reset
   always_ff @(posedge comm_clock)
      if (push && !bus.flush) mem[wr_ptr] <= bus.write_data;
   // pointers, occupancy and sticky overflow; flush wins over push/pop, drop wins over clear
   always_ff @(posedge comm_clock or posedge reset)
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            cnt <= cnt + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
         end
         ovf <= drop || (ovf && !bus.clear_overflow);
      end
   // all outputs decode straight from registers
   always_comb begin
      bus.tx_data  = mem[rd_ptr];
      bus.tx_valid = cnt != '0;
      bus.count    = cnt;
      bus.empty    = cnt == '0;
      bus.full     = cnt == DEPTH_CNT;
      bus.overflow = ovf;
   end
endmodule

// File: tb/tb_usart_tx_fifo.sv
// tb_usart_tx_fifo: randomized + directed scoreboard bench for usart_tx_fifo
module tb_usart_tx_fifo;
   localparam int DL = 4;
   localparam int D  = 16;
   logic comm_clock = 1'b0;
   logic reset      = 1'b1;
   usart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus();
   usart_tx_fifo #(.DEPTH_LOG2(DL)) dut (.comm_clock(comm_clock), .reset(reset), .bus(bus));
   always #5 comm_clock = ~comm_clock;
   int checks   = 0;
   int failures = 0;
   logic [7:0] q[$];
   logic [7:0] sb[$];
   logic ovf_m = 1'b0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   task automatic status(input string tag);
      check({tag, " count"}, 32'(bus.count), q.size());
      check({tag, " empty"}, 32'(bus.empty), q.size() == 0);
      check({tag, " full"}, 32'(bus.full), q.size() == D);
      check({tag, " tx_valid"}, 32'(bus.tx_valid), q.size() != 0);
      check({tag, " overflow"}, 32'(bus.overflow), 32'(ovf_m));
      if (q.size() != 0) check({tag, " tx_data"}, 32'(bus.tx_data), 32'(q[0]));
   endtask
   // called at posedge+1: checks state, drives one cycle of inputs, advances the model
   task automatic cycle(input string tag, input logic ws, input logic [7:0] wd,
                        input logic rdy, input logic fl, input logic clr);
      bit pop, push, drop;
      status(tag);
      bus.write_strobe   = ws;
      bus.write_data     = wd;
      bus.tx_ready       = rdy;
      bus.flush          = fl;
      bus.clear_overflow = clr;
      pop  = rdy && q.size() > 0;
      push = ws && (q.size() < D || pop);
      drop = ws && q.size() == D && !pop;
      if (pop) sb.push_back(q[0]);
      if (fl) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(wd);
      end
      ovf_m = drop ? 1'b1 : clr ? 1'b0 : ovf_m;
      @(posedge comm_clock);
      #1;
   endtask
   // monitor: every handshake seen on the bus must deliver the next expected byte
   always @(negedge comm_clock)
      if (!reset && bus.tx_valid && bus.tx_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pop actual=%0h required=none", bus.tx_data);
         end else check("pop data", 32'(bus.tx_data), 32'(sb.pop_front()));
      end
   initial begin
      bus.write_strobe   = 1'b0;
      bus.write_data     = 8'h00;
      bus.tx_ready       = 1'b0;
      bus.flush          = 1'b0;
      bus.clear_overflow = 1'b0;
      #2;
      status("reset");
      @(posedge comm_clock);
      #1;
      reset = 1'b0;
      cycle("r33 push", 1, 8'h41, 0, 0, 0);
      cycle("r33 pop", 0, 8'h00, 1, 0, 0);
      cycle("r33 empty ready", 0, 8'h00, 1, 0, 0);
      for (int i = 0; i < D; i++) cycle("r34 fill", 1, 8'(i), 0, 0, 0);
      cycle("r34 drop", 1, 8'hFF, 0, 0, 0);
      cycle("r34 clear", 0, 8'h00, 0, 0, 1);
      cycle("r35 push+pop full", 1, 8'hAA, 1, 0, 0);
      for (int i = 0; i < D + 2; i++) cycle("r34 drain", 0, 8'h00, 1, 0, 0);
      for (int i = 0; i < 40; i++) cycle("r36 wrap", i < 38, 8'(8'h80 + i), i > 2, 0, 0);
      for (int i = 0; i < 5; i++) cycle("r37 fill", 1, 8'(8'h30 + i), 0, 0, 0);
      cycle("r37 flush", 1, 8'h77, 0, 1, 0);
      cycle("r37 after", 0, 8'h00, 1, 0, 0);
      for (int i = 0; i < D; i++) cycle("rst fill", 1, 8'(8'hC0 + i), 0, 0, 0);
      cycle("rst drop", 1, 8'h99, 0, 0, 0);
      #2;
      reset = 1'b1;
      q.delete();
      ovf_m = 1'b0;
      #1;
      status("async reset");
      @(posedge comm_clock);
      #1;
      reset = 1'b0;
      cycle("post reset push", 1, 8'h5A, 0, 0, 0);
      cycle("post reset pop", 0, 8'h00, 1, 0, 0);
      for (int ph = 0; ph < 3; ph++) begin
         int wp;
         wp = ph == 0 ? 85 : ph == 1 ? 50 : 20;
         for (int i = 0; i < 500; i++)
            cycle("rand", $urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < 50,
                  $urandom_range(99) < 2, $urandom_range(99) < 5);
      end
      for (int i = 0; i < D + 1; i++) cycle("final drain", 0, 8'h00, 1, 0, 0);
      status("end");
      check("scoreboard drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
